// File: rtl/memoria_bus_ctrl.sv
// Single-word initiator for the 4-bit asynchronous memory bus (WR / ADDR / tri-state data).
// Build option MEMORIA_READBACK_EN adds a verify read after every write and reports mismatches on err.
module memoria_bus_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int RD_WAIT = 8,
  parameter int WR_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              WR,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] dataBus
);

  localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

`ifdef MEMORIA_READBACK_EN
  typedef enum logic [2:0] {IDLE, SETUP, READ_WAIT, WRITE_DRV, RECOVER, DONE, VERIFY} state_t;
  logic vsetup;
  logic err_q;
`else
  typedef enum logic [2:0] {IDLE, SETUP, READ_WAIT, WRITE_DRV, RECOVER, DONE} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              drive;
  logic [DATA_W-1:0] wdata_q;

  assign dataBus = drive ? wdata_q : {DATA_W{1'bz}};

  // Write data is pure payload: only captured, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) wdata_q <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
      WR    <= 1'b1;
      ADDR  <= '0;
      drive <= 1'b0;
      cnt   <= '0;
      we_q  <= 1'b0;
`ifdef MEMORIA_READBACK_EN
      vsetup <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          we_q  <= we;
          ADDR  <= addr;
          WR    <= ~we;
          busy  <= 1'b1;
          state <= SETUP;
`ifdef MEMORIA_READBACK_EN
          err_q <= 1'b0;
`endif
        end
        // Bus stays released here so the memory has let go before we drive it.
        SETUP: if (we_q) begin
          drive <= 1'b1;
          cnt   <= WR_LOAD;
          state <= WRITE_DRV;
        end else begin
          cnt   <= RD_LOAD;
          state <= READ_WAIT;
        end
        READ_WAIT: if (cnt == '0) begin
          rdata <= dataBus;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        WRITE_DRV: if (cnt == '0) begin
          drive <= 1'b0;
          state <= RECOVER;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        RECOVER: begin
          WR <= 1'b1;
`ifdef MEMORIA_READBACK_EN
          vsetup <= 1'b1;
          state  <= VERIFY;
`else
          done  <= 1'b1;
          state <= DONE;
`endif
        end
`ifdef MEMORIA_READBACK_EN
        // One setup cycle, then RD_WAIT cycles exactly like a normal read; rdata is left alone.
        VERIFY: if (vsetup) begin
          vsetup <= 1'b0;
          cnt    <= RD_LOAD;
        end else if (cnt == '0) begin
          err_q <= (dataBus != wdata_q);
          done  <= 1'b1;
          state <= DONE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMORIA_READBACK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
